masked_rom_matcher: RTL

- Parametrised successor of the team's ROM-driven pattern-match sequencer.
- On START it captures an input word, then walks a DEPTH-entry match table one entry per two cycles.
- Each entry holds two match masks and an output mask; for every entry that matches, the output mask is accumulated by OR or XOR.
- The table is writable through a port instead of being hard-coded; the block adds busy/done status and a match counter.

---
 rtl/masked_rom_matcher.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/masked_rom_matcher.sv
`default_nettype none
// ============================================================================
//  Module      : masked_rom_matcher
//  Description : Captures an input word on START, then walks a writable
//                DEPTH-entry match table (one entry every two cycles),
//                accumulating the output mask of every matching entry by
//                OR or XOR. Reports busy/done status and a match count.
//  Revision    : 1.0 - initial release
// ============================================================================
module masked_rom_matcher #(
   parameter int DW       = 8,
   parameter int OW       = 4,
   parameter int DEPTH    = 8,
   parameter int ACC_MODE = 0,
   parameter int AW       = $clog2(DEPTH),
   parameter int CW       = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              START,
   input  logic [DW-1:0]     I,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [2*DW+OW-1:0] wr_data,
   output logic [OW-1:0]     O,
   output logic [CW-1:0]     match_cnt,
   output logic              busy,
   output logic              done,
   output logic              wr_err
);

   localparam int            EW        = 2*DW + OW;
   localparam logic [AW:0]   DEPTH_C   = DEPTH[AW:0];
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      EVAL = 2'd2,
      NEXT = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nx;

   logic [EW-1:0]   tbl [DEPTH];
   logic [DW-1:0]   x;
   logic [OW-1:0]   acc;
   logic [CW-1:0]   cnt;
   logic [AW-1:0]   addr;

   logic [EW-1:0]   entry;
   logic [DW-1:0]   r1;
   logic [DW-1:0]   r2;
   logic [OW-1:0]   om;
   logic            match;
   logic [OW-1:0]   acc_nx;
   logic            wr_addr_ok;
   logic            last_entry;

   // Current entry fields and match evaluation against the captured word
   assign entry      = tbl[addr];
   assign r1         = entry[EW-1 -: DW];
   assign r2         = entry[OW +: DW];
   assign om         = entry[OW-1:0];
   assign match      = &((r2 & ~x) | (r1 & x) | (r1 & r2));
   assign wr_addr_ok = ({1'b0, wr_addr} < DEPTH_C);
   assign last_entry = (addr == LAST_ADDR);
   assign busy       = (state != IDLE);

   // Accumulation operator chosen at elaboration time
   generate
      if (ACC_MODE == 1) begin : g_acc_xor
         assign acc_nx = acc ^ om;
      end else begin : g_acc_or
         assign acc_nx = acc | om;
      end
   endgenerate

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; a held START at the final NEXT stalls the run
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (START) state_nx = INIT;
         INIT:    state_nx = EVAL;
         EVAL:    state_nx = NEXT;
         NEXT: begin
            if (!last_entry)  state_nx = EVAL;
            else if (!START)  state_nx = IDLE;
            else              state_nx = NEXT;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Match table: writable only in IDLE and only for in-range addresses
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) tbl[k] <= '0;
      end else if (wr_en && (state == IDLE) && wr_addr_ok) begin
         tbl[wr_addr] <= wr_data;
      end
   end

   // Run datapath, result registers and status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         x         <= '0;
         acc       <= '0;
         cnt       <= '0;
         addr      <= '0;
         O         <= '0;
         match_cnt <= '0;
         done      <= 1'b0;
         wr_err    <= 1'b0;
      end else begin
         done   <= 1'b0;
         wr_err <= wr_en && ((state != IDLE) || !wr_addr_ok);
         case (state)
            INIT: begin
               x    <= I;
               acc  <= '0;
               cnt  <= '0;
               addr <= '0;
            end
            EVAL: begin
               if (match) begin
                  acc <= acc_nx;
                  cnt <= cnt + CW'(1);
               end
            end
            NEXT: begin
               if (!last_entry) begin
                  addr <= addr + AW'(1);
               end else if (!START) begin
                  O         <= acc;
                  match_cnt <= cnt;
                  done      <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
